// File: rtl/msk_aes_pkg.sv
// Shared constants and types for the masked AES datapath slice.
package msk_aes_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned COL_BYTES = 4;
  localparam int unsigned CNT_W     = 2;

  // Ping-pong slot index.
  typedef enum logic {
    SLOT0 = 1'b0,
    SLOT1 = 1'b1
  } slot_t;

  function automatic slot_t other_slot(input slot_t s);
    return (s == SLOT0) ? SLOT1 : SLOT0;
  endfunction

endpackage

// File: rtl/msk_col_slot.sv
// One ping-pong column buffer: four masked byte registers, the inverse/bypass
// flags captured with byte 0, and the full flag.
module msk_col_slot
  import msk_aes_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear,
  input  logic [COL_BYTES-1:0]                  byte_we,
  input  logic [BYTE_W*d-1:0]                   wr_byte,
  input  logic                                  flag_we,
  input  logic                                  wr_inverse,
  input  logic                                  wr_bypass,
  input  logic                                  set_full,
  input  logic                                  clr_full,
  output logic [COL_BYTES-1:0][BYTE_W*d-1:0]    col,
  output logic                                  inverse,
  output logic                                  bypass,
  output logic                                  full
);

  // Byte registers: plain copies of the incoming sharing, one enable per row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
    end else begin
      for (int unsigned i = 0; i < COL_BYTES; i++) begin
        if (byte_we[i]) col[i] <= wr_byte;
      end
    end
  end

  // Direction and last-round flags, captured with the first byte of the column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inverse <= 1'b0;
      bypass  <= 1'b0;
    end else if (flag_we) begin
      inverse <= wr_inverse;
      bypass  <= wr_bypass;
    end
  end

  // Full flag: flush wins, then completion, then consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/msk_mc_column_gather.sv
// Gathers masked bytes (one per cycle) into 4-byte columns for the combined
// masked MixColumns, double-buffered so filling overlaps consumption.
module msk_mc_column_gather
  import msk_aes_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BYTE_W*d-1:0]   in_byte,
  input  logic                  in_inverse,
  input  logic                  in_bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BYTE_W*d-1:0]   out0,
  output logic [BYTE_W*d-1:0]   out1,
  output logic [BYTE_W*d-1:0]   out2,
  output logic [BYTE_W*d-1:0]   out3,
  output logic                  out_inverse,
  output logic                  out_bypass
);

  localparam int unsigned W = BYTE_W * d;

  logic [CNT_W-1:0]                      cnt;
  slot_t                                 wr_slot;
  slot_t                                 rd_slot;

  logic [1:0]                            full;
  logic [1:0]                            slot_inv;
  logic [1:0]                            slot_byp;
  logic [1:0][COL_BYTES-1:0][W-1:0]      slot_col;

  logic [1:0][COL_BYTES-1:0]             byte_we;
  logic [1:0]                            flag_we;
  logic [1:0]                            set_full;
  logic [1:0]                            clr_full;

  logic                                  in_acc;
  logic                                  out_acc;
  logic                                  last_byte;

  assign in_ready  = !full[wr_slot];
  assign out_valid = full[rd_slot];
  assign in_acc    = in_valid && in_ready && !clear;
  assign out_acc   = out_valid && out_ready && !clear;
  assign last_byte = (cnt == CNT_W'(COL_BYTES - 1));

  // Per-slot write/flag/full controls, steered by the fill and drain pointers.
  always_comb begin
    byte_we  = '0;
    flag_we  = '0;
    set_full = '0;
    clr_full = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      if (in_acc && (wr_slot == slot_t'(k))) begin
        byte_we[k]  = COL_BYTES'(1) << cnt;
        flag_we[k]  = (cnt == '0);
        set_full[k] = last_byte;
      end
      if (out_acc && (rd_slot == slot_t'(k))) begin
        clr_full[k] = 1'b1;
      end
    end
  end

  msk_col_slot #(.d(d)) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .byte_we    (byte_we[0]),
    .wr_byte    (in_byte),
    .flag_we    (flag_we[0]),
    .wr_inverse (in_inverse),
    .wr_bypass  (in_bypass),
    .set_full   (set_full[0]),
    .clr_full   (clr_full[0]),
    .col        (slot_col[0]),
    .inverse    (slot_inv[0]),
    .bypass     (slot_byp[0]),
    .full       (full[0])
  );

  msk_col_slot #(.d(d)) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .byte_we    (byte_we[1]),
    .wr_byte    (in_byte),
    .flag_we    (flag_we[1]),
    .wr_inverse (in_inverse),
    .wr_bypass  (in_bypass),
    .set_full   (set_full[1]),
    .clr_full   (clr_full[1]),
    .col        (slot_col[1]),
    .inverse    (slot_inv[1]),
    .bypass     (slot_byp[1]),
    .full       (full[1])
  );

  // Fill counter and ping-pong pointers; flush returns them to slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      wr_slot <= SLOT0;
      rd_slot <= SLOT0;
    end else if (clear) begin
      cnt     <= '0;
      wr_slot <= SLOT0;
      rd_slot <= SLOT0;
    end else begin
      if (in_acc) begin
        cnt <= cnt + 1'b1;
        if (last_byte) wr_slot <= other_slot(wr_slot);
      end
      if (out_acc) rd_slot <= other_slot(rd_slot);
    end
  end

  // Output mux: the only logic between share registers and the outputs.
  always_comb begin
    out0        = slot_col[rd_slot][0];
    out1        = slot_col[rd_slot][1];
    out2        = slot_col[rd_slot][2];
    out3        = slot_col[rd_slot][3];
    out_inverse = slot_inv[rd_slot];
    out_bypass  = slot_byp[rd_slot];
  end

endmodule

// File: tb/tb_msk_mc_column_gather.sv
// Scoreboard bench for msk_mc_column_gather at d=2 (share0 = bits 7:0,
// share1 = bits 15:8; unmasked byte = share0 ^ share1).
module tb_msk_mc_column_gather;

  localparam int D = 2;
  localparam int W = 8 * D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_byte;
  logic         in_inverse;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out0, out1, out2, out3;
  logic         out_inverse;
  logic         out_bypass;

  always #5 clk = ~clk;

  msk_mc_column_gather #(.d(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_byte     (in_byte),
    .in_inverse  (in_inverse),
    .in_bypass   (in_bypass),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .out_inverse (out_inverse),
    .out_bypass  (out_bypass)
  );

  typedef struct packed {
    logic [4*W-1:0] raw;
    logic           inv;
    logic           byp;
  } col_t;

  col_t           sb_q[$];
  int             checks = 0;
  int             errors = 0;
  int             delivered = 0;
  int             m_cnt = 0;
  logic [4*W-1:0] m_col;
  logic           m_inv, m_byp;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] unmask(input logic [W-1:0] s);
    return s[7:0] ^ s[15:8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [7:0] a0, a1, a2, a3);
    logic [7:0] r0, r1, r2, r3;
    r0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    r3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    return {r0, r1, r2, r3};
  endfunction

  // One cycle: drive at negedge, check outputs against the model, then
  // update the model with whatever handshakes occur at the coming posedge.
  task automatic step(input logic iv, input logic [7:0] b, input logic inv,
                      input logic byp, input logic ordy, output logic acc);
    logic [7:0]   r;
    logic [W-1:0] sh;
    col_t         e;
    @(negedge clk);
    r          = 8'($urandom);
    sh         = {r, b ^ r};
    clear      = 1'b0;
    in_valid   = iv;
    in_byte    = sh;
    in_inverse = inv;
    in_bypass  = byp;
    out_ready  = ordy;
    #1;
    check_val("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
    check_val("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
    acc = iv && in_ready;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("col_raw", {out3, out2, out1, out0}, e.raw);
        check_val("col_flags", {62'd0, out_inverse, out_bypass}, {62'd0, e.inv, e.byp});
        delivered++;
      end
    end
    if (acc) begin
      if (m_cnt == 0) begin
        m_inv = inv;
        m_byp = byp;
      end
      m_col[m_cnt*W +: W] = sh;
      if (m_cnt == 3) begin
        sb_q.push_back('{raw: m_col, inv: m_inv, byp: m_byp});
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // ordy_mode: 0 = out_ready low, 1 = high, 2 = random per cycle.
  task automatic send_byte(input logic [7:0] b, input logic inv, input logic byp, input int ordy_mode);
    logic acc;
    int   n;
    n = 0;
    do begin
      step(1'b1, b, inv, byp, (ordy_mode == 2) ? 1'($urandom_range(0, 1)) : (ordy_mode == 1), acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) check_val("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while ((sb_q.size() != 0) && n < 64) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    check_val("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic flush_model();
    sb_q.delete();
    m_cnt = 0;
  endtask

  logic        acc_t;
  logic [31:0] col_u;
  int          base_delivered;

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_byte    = '0;
    in_inverse = 1'b0;
    in_bypass  = 1'b0;
    out_ready  = 1'b0;
    #2;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_data", {out3, out2, out1, out0}, 64'd0);
    check_val("rst_out_flags", {62'd0, out_inverse, out_bypass}, 64'd0);
    #20 rst_n = 1'b1;

    // Basic column with the MixColumns reference vector.
    send_byte(8'hdb, 1'b0, 1'b0, 1);
    send_byte(8'h13, 1'b0, 1'b0, 1);
    send_byte(8'h53, 1'b0, 1'b0, 1);
    send_byte(8'h45, 1'b0, 1'b0, 1);
    @(posedge clk);
    #1;
    check_val("latency_valid", 64'(out_valid), 64'd1);
    col_u = {unmask(out0), unmask(out1), unmask(out2), unmask(out3)};
    check_val("basic_unmasked", 64'(col_u), 64'hdb135345);
    check_val("basic_inverse", 64'(out_inverse), 64'd0);
    check_val("basic_mix", 64'(mixcol(col_u[31:24], col_u[23:16], col_u[15:8], col_u[7:0])), 64'h8e4da1bc);
    drain();

    // Twelve bytes with the consumer stalled: fill stops after byte 8.
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h18, 1'b0, 1'b0, 1'b0, acc_t);
      check_val("stall_no_accept", 64'(acc_t), 64'd0);
      check_val("stall_hold_col1", 64'({unmask(out0), unmask(out1), unmask(out2), unmask(out3)}), 64'h10111213);
    end
    base_delivered = delivered;
    for (int i = 8; i < 12; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0, 1);
    drain();
    check_val("twelve_delivered", 64'(delivered - base_delivered), 64'd3);

    // Column accept in the same cycle as completion of the next column.
    for (int i = 0; i < 4; i++) send_byte(8'(8'h20 + i), 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h30 + i), 1'b0, 1'b0, 0);
    send_byte(8'h33, 1'b0, 1'b0, 1);
    @(posedge clk);
    #1;
    check_val("same_cycle_valid", 64'(out_valid), 64'd1);
    check_val("same_cycle_next", 64'({unmask(out0), unmask(out1), unmask(out2), unmask(out3)}), 64'h30313233);
    drain();

    // Flags sampled only with byte 0.
    send_byte(8'h40, 1'b1, 1'b0, 0);
    for (int i = 1; i < 4; i++) send_byte(8'(8'h40 + i), 1'b0, 1'b1, 0);
    send_byte(8'h50, 1'b0, 1'b1, 0);
    for (int i = 1; i < 4; i++) send_byte(8'(8'h50 + i), 1'b1, 1'b0, 0);
    drain();

    // Clear discards a partial column.
    send_byte(8'h60, 1'b1, 1'b1, 0);
    send_byte(8'h61, 1'b1, 1'b1, 0);
    @(negedge clk);
    clear     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    flush_model();
    #1;
    check_val("clear_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h70 + i), 1'b0, 1'b0, 1);
    drain();

    // Asynchronous reset mid-column, with a full column waiting.
    for (int i = 0; i < 6; i++) send_byte(8'(8'h80 + i), 1'b1, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_out_valid", 64'(out_valid), 64'd0);
    check_val("arst_in_ready", 64'(in_ready), 64'd1);
    check_val("arst_out_data", {out3, out2, out1, out0}, 64'd0);
    check_val("arst_out_inverse", 64'(out_inverse), 64'd0);
    flush_model();
    #10 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i), 1'b0, 1'b1, 1);
    drain();

    // Fixed unmasked stream, random shares, random gaps and stalls.
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 8'h00, 1'b0, 1'b0, 1'($urandom_range(0, 1)), acc_t);
        send_byte(8'(8'hc0 + i), (i == 0) ? 1'b1 : 1'b0, 1'b0, 2);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
